// File: rtl/blockade_pkg.sv
// Shared constants for the Blockade input front-end: game modes, coin FSM
// states and bit positions within the raw button vector.
package blockade_pkg;

   localparam logic [1:0] GAME_BLOCKADE = 2'd0;
   localparam logic [1:0] GAME_COMOTION = 2'd1;
   localparam logic [1:0] GAME_HUSTLE   = 2'd2;
   localparam logic [1:0] GAME_BLASTO   = 2'd3;

   localparam int NUM_INPUTS = 13;

   localparam int IDX_P1_R   = 0;
   localparam int IDX_P1_L   = 1;
   localparam int IDX_P1_D   = 2;
   localparam int IDX_P1_U   = 3;
   localparam int IDX_P2_R   = 4;
   localparam int IDX_P2_L   = 5;
   localparam int IDX_P2_D   = 6;
   localparam int IDX_P2_U   = 7;
   localparam int IDX_COIN   = 8;
   localparam int IDX_START1 = 9;
   localparam int IDX_START2 = 10;
   localparam int IDX_FIRE1  = 11;
   localparam int IDX_FIRE2  = 12;

   typedef enum logic [1:0] {
      IDLE,
      PULSE,
      HOLDOFF
   } coin_state_t;

   // Bits needed for a counter that runs from 0 to n-1.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/input_debounce.sv
// One button bit: 2-FF synchroniser followed by a stable-count debouncer.
module input_debounce
   import blockade_pkg::*;
#(
   parameter int unsigned DB_CYCLES = 20000
) (
   input  logic clk_sys,
   input  logic reset,
   input  logic raw,
   output logic db
);

   localparam int unsigned CW = cnt_width(DB_CYCLES);

   logic [1:0]    sync_q;
   logic [CW-1:0] cnt;
   logic          synced;

   assign synced = sync_q[1];

   // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
   // so the synchroniser stages shift instead of collapsing into one.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
         cnt    <= '0;
         db     <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], raw};
         if (synced == db) begin
            cnt <= '0;
         end else if (cnt == CW'(DB_CYCLES - 1)) begin
            db  <= synced;
            cnt <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/blockade_input_ctrl.sv
// Blockade input front-end: debounces the buttons, shapes the coin pulse and
// builds the per-game active-low input bytes for the core.
module blockade_input_ctrl
   import blockade_pkg::*;
#(
   parameter int unsigned DB_CYCLES           = 20000,
   parameter int unsigned COIN_PULSE_CYCLES   = 200000,
   parameter int unsigned COIN_HOLDOFF_CYCLES = 100000
) (
   input  logic                  clk_sys,
   input  logic                  reset,
   input  logic [1:0]            game_mode,
   input  logic [NUM_INPUTS-1:0] inputs,
   input  logic [3:0]            dip_sw,
   input  logic [7:0]            dip_ext,
   output logic [7:0]            in_1,
   output logic [7:0]            in_2,
   output logic [7:0]            in_4,
   output logic                  coin,
   output logic                  coin_busy
);

   localparam int unsigned COIN_MAX = (COIN_PULSE_CYCLES > COIN_HOLDOFF_CYCLES) ?
                                      COIN_PULSE_CYCLES : COIN_HOLDOFF_CYCLES;
   localparam int unsigned CCW = cnt_width(COIN_MAX);
   localparam logic        BOOM = 1'b0;

   logic [1:0]            rst_sync;
   logic                  rst_int;
   logic [NUM_INPUTS-1:0] db;
   logic                  db_coin;
   logic                  db_coin_q;
   coin_state_t           state;
   logic [CCW-1:0]        coin_cnt;
   logic [7:0]            in_1_d;
   logic [7:0]            in_2_d;
   logic [7:0]            in_4_d;
   logic [7:0]            p_blockade;
   logic [7:0]            p_comotion;

   // Reset asserts immediately but releases only on a clock edge.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         rst_sync <= 2'b11;
      end else begin
         rst_sync <= {rst_sync[0], 1'b0};
      end
   end

   assign rst_int = rst_sync[1];

   for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_db
      input_debounce #(
         .DB_CYCLES (DB_CYCLES)
      ) u_db (
         .clk_sys (clk_sys),
         .reset   (rst_int),
         .raw     (inputs[i]),
         .db      (db[i])
      );
   end

   assign db_coin = db[IDX_COIN];

   always_ff @(posedge clk_sys or posedge rst_int) begin
      if (rst_int) begin
         state     <= IDLE;
         coin_cnt  <= '0;
         coin      <= 1'b0;
         coin_busy <= 1'b0;
         db_coin_q <= 1'b0;
      end else begin
         db_coin_q <= db_coin;
         case (state)
            IDLE: begin
               if (db_coin && !db_coin_q) begin
                  state     <= PULSE;
                  coin      <= 1'b1;
                  coin_busy <= 1'b1;
                  coin_cnt  <= '0;
               end
            end
            PULSE: begin
               if (coin_cnt == CCW'(COIN_PULSE_CYCLES - 1)) begin
                  state    <= HOLDOFF;
                  coin     <= 1'b0;
                  coin_cnt <= '0;
               end else begin
                  coin_cnt <= coin_cnt + CCW'(1);
               end
            end
            HOLDOFF: begin
               // Counter saturates; a still-held button keeps us here.
               if (coin_cnt == CCW'(COIN_HOLDOFF_CYCLES - 1)) begin
                  if (!db_coin) begin
                     state     <= IDLE;
                     coin_busy <= 1'b0;
                  end
               end else begin
                  coin_cnt <= coin_cnt + CCW'(1);
               end
            end
            default: begin
               state     <= IDLE;
               coin      <= 1'b0;
               coin_busy <= 1'b0;
            end
         endcase
      end
   end

   assign p_blockade = ~{db[IDX_P1_L], db[IDX_P1_D], db[IDX_P1_R], db[IDX_P1_U],
                         db[IDX_P2_L], db[IDX_P2_D], db[IDX_P2_R], db[IDX_P2_U]};
   assign p_comotion = ~{db[IDX_P2_L], db[IDX_P2_D], db[IDX_P2_R], db[IDX_P2_U],
                         db[IDX_P1_L], db[IDX_P1_D], db[IDX_P1_R], db[IDX_P1_U]};

   // NOTE: every output gets a default before the case so no path leaves a
   // value unassigned, which would otherwise infer a latch.
   always_comb begin
      in_1_d = 8'hFF;
      in_2_d = 8'hFF;
      in_4_d = 8'hFF;
      case (game_mode)
         GAME_BLOCKADE: begin
            in_1_d = ~{coin, dip_sw[2:0], 1'b0, BOOM, 2'b00};
            in_2_d = p_blockade;
         end
         GAME_COMOTION: begin
            in_1_d = ~{coin, 2'b00, db[IDX_START1] | db[IDX_START2], dip_sw[0], BOOM, 2'b00};
            in_2_d = p_comotion;
            in_4_d = p_comotion;
         end
         GAME_HUSTLE: begin
            in_1_d = ~{coin, 2'b00, db[IDX_START2], db[IDX_START1], dip_sw[0], dip_sw[2:1]};
            in_2_d = p_blockade;
            in_4_d = dip_ext;
         end
         GAME_BLASTO: begin
            in_1_d = ~{coin, 3'b000, dip_sw[0], dip_sw[1], dip_sw[3:2]};
            in_2_d = ~{db[IDX_FIRE1], db[IDX_START2], db[IDX_START1], 4'b0000, db[IDX_FIRE2]};
            in_4_d = ~{db[IDX_P1_U], db[IDX_P1_L], db[IDX_P1_D], db[IDX_P1_R],
                       db[IDX_P2_U], db[IDX_P2_L], db[IDX_P2_D], db[IDX_P2_R]};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_sys or posedge rst_int) begin
      if (rst_int) begin
         in_1 <= 8'hFF;
         in_2 <= 8'hFF;
         in_4 <= 8'hFF;
      end else begin
         in_1 <= in_1_d;
         in_2 <= in_2_d;
         in_4 <= in_4_d;
      end
   end

endmodule

// File: tb/tb_blockade_input_ctrl.sv
// Scoreboard bench for blockade_input_ctrl: stimulus queues cycle-stamped
// expectations, a negedge monitor pops and compares them.
module tb_blockade_input_ctrl;
   import blockade_pkg::*;

   logic        clk_sys = 1'b0;
   logic        reset   = 1'b0;
   logic [1:0]  game_mode;
   logic [12:0] inputs;
   logic [3:0]  dip_sw;
   logic [7:0]  dip_ext;
   logic [7:0]  in_1, in_2, in_4;
   logic        coin, coin_busy;

   blockade_input_ctrl #(
      .DB_CYCLES           (4),
      .COIN_PULSE_CYCLES   (8),
      .COIN_HOLDOFF_CYCLES (6)
   ) dut (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .game_mode (game_mode),
      .inputs    (inputs),
      .dip_sw    (dip_sw),
      .dip_ext   (dip_ext),
      .in_1      (in_1),
      .in_2      (in_2),
      .in_4      (in_4),
      .coin      (coin),
      .coin_busy (coin_busy)
   );

   always #5 clk_sys = ~clk_sys;

   int cyc = 0;
   always @(posedge clk_sys) cyc <= cyc + 1;

   localparam logic [4:0] EN_IN1  = 5'b00001;
   localparam logic [4:0] EN_IN2  = 5'b00010;
   localparam logic [4:0] EN_IN4  = 5'b00100;
   localparam logic [4:0] EN_COIN = 5'b01000;
   localparam logic [4:0] EN_BUSY = 5'b10000;
   localparam logic [4:0] EN_ALL  = 5'b11111;

   typedef struct {
      string      name;
      int         cyc;
      logic [4:0] en;
      logic [7:0] in1;
      logic [7:0] in2;
      logic [7:0] in4;
      logic       coin;
      logic       busy;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks   = 0;
   int   failures = 0;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s @cycle %0d: got %02h want %02h", name, cyc, act, exp);
      end
   endtask

   task automatic expect_at(input string name, input int c, input logic [4:0] en,
                            input logic [7:0] e1, input logic [7:0] e2, input logic [7:0] e4,
                            input logic ec, input logic eb);
      exp_t e;
      int   i;
      e.name = name; e.cyc = c; e.en = en;
      e.in1 = e1; e.in2 = e2; e.in4 = e4; e.coin = ec; e.busy = eb;
      i = 0;
      while (i < sb.size() && sb[i].cyc <= c) i++;
      sb.insert(i, e);
   endtask

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk_sys);
   endtask

   always @(negedge clk_sys) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         mon_e = sb.pop_front();
         if (mon_e.cyc < cyc) begin
            checks++;
            failures++;
            $display("FAIL %s: slot for cycle %0d missed (now %0d)", mon_e.name, mon_e.cyc, cyc);
         end else begin
            if (mon_e.en[0]) check({mon_e.name, "/in_1"}, in_1, mon_e.in1);
            if (mon_e.en[1]) check({mon_e.name, "/in_2"}, in_2, mon_e.in2);
            if (mon_e.en[2]) check({mon_e.name, "/in_4"}, in_4, mon_e.in4);
            if (mon_e.en[3]) check({mon_e.name, "/coin"}, {7'b0, coin}, {7'b0, mon_e.coin});
            if (mon_e.en[4]) check({mon_e.name, "/coin_busy"}, {7'b0, coin_busy}, {7'b0, mon_e.busy});
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      game_mode = GAME_BLOCKADE;
      inputs    = '0;
      dip_sw    = 4'b0011;
      dip_ext   = 8'h00;

      // Reset state, then idle Blockade mapping
      @(negedge clk_sys);
      reset = 1'b1;
      expect_at("reset", cyc + 1, EN_ALL, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
      wait_n(2);
      reset = 1'b0;
      wait_n(5);
      expect_at("idle_mode0", cyc + 1, EN_ALL, 8'hCF, 8'hFF, 8'hFF, 1'b0, 1'b0);
      wait_n(3);

      // P1U press: 7-cycle latency raw edge -> in_2
      t = cyc;
      inputs[IDX_P1_U] = 1'b1;
      expect_at("p1u_pre", t + 6, EN_IN2, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b0);
      expect_at("p1u_on", t + 7, EN_IN1 | EN_IN2 | EN_IN4, 8'hCF, 8'hEF, 8'hFF, 1'b0, 1'b0);
      wait_n(10);
      t = cyc;
      inputs[IDX_P1_U] = 1'b0;
      expect_at("p1u_rel_pre", t + 6, EN_IN2, 8'h00, 8'hEF, 8'h00, 1'b0, 1'b0);
      expect_at("p1u_rel", t + 7, EN_IN2, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b0);
      wait_n(10);

      // 3-cycle glitch is rejected
      t = cyc;
      inputs[IDX_P1_U] = 1'b1;
      for (int k = 1; k <= 12; k++)
         expect_at("glitch", t + k, EN_IN2, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b0);
      wait_n(3);
      inputs[IDX_P1_U] = 1'b0;
      wait_n(12);

      // Coin held 40 cycles: one 8-cycle pulse, busy until release clears holdoff
      t = cyc;
      inputs[IDX_COIN] = 1'b1;
      for (int k = 1; k <= 50; k++) begin
         logic [4:0] en;
         en = EN_COIN | EN_BUSY;
         if (k >= 6 && k <= 17) en = en | EN_IN1;
         expect_at("coin_held", t + k, en, (k >= 8 && k <= 15) ? 8'h4F : 8'hCF, 8'h00, 8'h00,
                   (k >= 7 && k <= 14), (k >= 7 && k <= 46));
      end
      wait_n(40);
      inputs[IDX_COIN] = 1'b0;
      wait_n(20);

      // Press landing in holdoff is dropped; press after idle gives a new pulse
      t = cyc;
      for (int k = 1; k <= 52; k++)
         expect_at("coin_holdoff", t + k, EN_COIN | EN_BUSY, 8'h00, 8'h00, 8'h00,
                   (k >= 7 && k <= 14) || (k >= 37 && k <= 44),
                   (k >= 7 && k <= 23) || (k >= 37 && k <= 50));
      inputs[IDX_COIN] = 1'b1;
      wait_n(6);
      inputs[IDX_COIN] = 1'b0;
      wait_n(5);
      inputs[IDX_COIN] = 1'b1;
      wait_n(6);
      inputs[IDX_COIN] = 1'b0;
      wait_n(13);
      inputs[IDX_COIN] = 1'b1;
      wait_n(6);
      inputs[IDX_COIN] = 1'b0;
      wait_n(20);

      // Comotion: start2 and P1U, P3/P4 mirror P1/P2
      t = cyc;
      game_mode = GAME_COMOTION;
      dip_sw    = 4'b0001;
      inputs[IDX_START2] = 1'b1;
      inputs[IDX_P1_U]   = 1'b1;
      expect_at("comotion_sw", t + 1, EN_IN1 | EN_IN2 | EN_IN4, 8'hF7, 8'hFF, 8'hFF, 1'b0, 1'b0);
      expect_at("comotion_pre", t + 6, EN_IN1 | EN_IN2, 8'hF7, 8'hFF, 8'h00, 1'b0, 1'b0);
      expect_at("comotion_btn", t + 7, EN_IN1 | EN_IN2 | EN_IN4, 8'hE7, 8'hFE, 8'hFE, 1'b0, 1'b0);
      wait_n(10);
      inputs = '0;
      wait_n(10);

      // Hustle: dip_ext raw on in_4, start1, P2U in Blockade order
      t = cyc;
      game_mode = GAME_HUSTLE;
      dip_ext   = 8'hD1;
      inputs[IDX_START1] = 1'b1;
      inputs[IDX_P2_U]   = 1'b1;
      expect_at("hustle_sw", t + 1, EN_IN1 | EN_IN2 | EN_IN4, 8'hFB, 8'hFF, 8'hD1, 1'b0, 1'b0);
      expect_at("hustle_btn", t + 7, EN_IN1 | EN_IN2 | EN_IN4, 8'hF3, 8'hFE, 8'hD1, 1'b0, 1'b0);
      wait_n(10);
      inputs = '0;
      wait_n(10);

      // Blasto: fire1 + P2R
      t = cyc;
      game_mode = GAME_BLASTO;
      inputs[IDX_FIRE1] = 1'b1;
      inputs[IDX_P2_R]  = 1'b1;
      expect_at("blasto_sw", t + 1, EN_IN1 | EN_IN2 | EN_IN4, 8'hF7, 8'hFF, 8'hFF, 1'b0, 1'b0);
      expect_at("blasto_btn", t + 7, EN_IN1 | EN_IN2 | EN_IN4, 8'hF7, 8'h7F, 8'hFE, 1'b0, 1'b0);
      wait_n(10);

      // Reset in the middle of a coin pulse
      t = cyc;
      inputs[IDX_COIN] = 1'b1;
      for (int k = 1; k <= 7; k++)
         expect_at("blasto_coin", t + k, EN_COIN, 8'h00, 8'h00, 8'h00, (k >= 7), 1'b0);
      wait_n(8);
      expect_at("mid_pulse", t + 9, EN_ALL, 8'h77, 8'h7F, 8'hFE, 1'b1, 1'b1);
      @(negedge clk_sys);
      @(posedge clk_sys);
      #1 reset = 1'b1;
      #1 expect_at("reset_mid_pulse", cyc, EN_ALL, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
      inputs = '0;
      wait_n(3);
      reset = 1'b0;
      wait_n(5);
      expect_at("after_reset", cyc + 1, EN_ALL, 8'hF7, 8'hFF, 8'hFF, 1'b0, 1'b0);

      for (int k = 0; k < 100 && sb.size() > 0; k++) @(negedge clk_sys);
      while (sb.size() > 0) begin
         mon_e = sb.pop_front();
         checks++;
         failures++;
         $display("FAIL %s: slot for cycle %0d never checked", mon_e.name, mon_e.cyc);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
